// File: rtl/gpio_ctrl_p.sv
// gpio_ctrl_p: parametrised GPIO controller between the MCU register bus and the pad ring.
// Per-pin direction and output data, a 2-flop input synchroniser, a programmable debounce
// filter, rise/fall edge detection into sticky W1C status, and a single masked irq.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   wr_en    register write strobe (single cycle)
//   rd_en    register read strobe (single cycle)
//   addr     register address (0 DIR, 1 DOUT, 2 DIN, 3 IRQ_EN, 4 RISE_EN, 5 FALL_EN,
//            6 STATUS (W1C), 7 DB_LIMIT)
//   wdata    write data
//   rdata    registered read data, one cycle after rd_en
//   rvalid   high one cycle after rd_en
//   pin_in   raw asynchronous pad inputs
//   pin_out  pad output data (DOUT)
//   pin_oe   pad output enable (DIR, 1 = drive)
//   irq      OR of STATUS & IRQ_EN, decoded from registers only
module gpio_ctrl_p #(
  parameter int unsigned N_PINS     = 16,
  parameter int unsigned DB_W       = 4,
  parameter int unsigned DB_DEFAULT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [2:0]        addr,
  input  logic [N_PINS-1:0] wdata,
  output logic [N_PINS-1:0] rdata,
  output logic              rvalid,
  input  logic [N_PINS-1:0] pin_in,
  output logic [N_PINS-1:0] pin_out,
  output logic [N_PINS-1:0] pin_oe,
  output logic              irq
);

  localparam logic [2:0] A_DIR      = 3'd0;
  localparam logic [2:0] A_DOUT     = 3'd1;
  localparam logic [2:0] A_DIN      = 3'd2;
  localparam logic [2:0] A_IRQ_EN   = 3'd3;
  localparam logic [2:0] A_RISE_EN  = 3'd4;
  localparam logic [2:0] A_FALL_EN  = 3'd5;
  localparam logic [2:0] A_STATUS   = 3'd6;
  localparam logic [2:0] A_DB_LIMIT = 3'd7;

  logic [N_PINS-1:0] dir, dout, irq_en, rise_en, fall_en, status;
  logic [DB_W-1:0]   db_limit;
  logic [N_PINS-1:0] sync1, sync2, stable, stable_q;
  logic [DB_W-1:0]   cnt     [N_PINS];
  logic [DB_W-1:0]   cnt_nxt [N_PINS];
  logic [N_PINS-1:0] stable_nxt;
  logic [DB_W-1:0]   lim_eff;
  logic [N_PINS-1:0] set_mask, clr_mask;
  logic [N_PINS-1:0] rd_mux;

  assign pin_oe  = dir;
  assign pin_out = dout;
  assign irq     = |(status & irq_en);

  // Debounce: count consecutive mismatches of sync against stable; a limit of 0 acts as 1.
  // The compare against L-1 also makes a lowered limit take effect on the very next edge.
  always_comb begin
    lim_eff    = (db_limit == '0) ? DB_W'(1) : db_limit;
    stable_nxt = stable;
    for (int i = 0; i < int'(N_PINS); i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] >= lim_eff - DB_W'(1)) begin
          stable_nxt[i] = sync2[i];
        end else if (cnt[i] != '1) begin
          cnt_nxt[i] = cnt[i] + DB_W'(1);
        end else begin
          cnt_nxt[i] = cnt[i];
        end
      end
    end
  end

  // Edge events come from the registered previous stable value; a set beats a W1C clear.
  always_comb begin
    set_mask = ((stable & ~stable_q) & rise_en) | ((~stable & stable_q) & fall_en);
    clr_mask = (wr_en && (addr == A_STATUS)) ? wdata : '0;
  end

  // Read decode on pre-write register values.
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_DIR:      rd_mux = dir;
      A_DOUT:     rd_mux = dout;
      A_DIN:      rd_mux = stable;
      A_IRQ_EN:   rd_mux = irq_en;
      A_RISE_EN:  rd_mux = rise_en;
      A_FALL_EN:  rd_mux = fall_en;
      A_STATUS:   rd_mux = status;
      A_DB_LIMIT: rd_mux = N_PINS'(db_limit);
      default:    rd_mux = '0;
    endcase
  end

  // Control registers and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir      <= '0;
      dout     <= '0;
      irq_en   <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      db_limit <= DB_W'(DB_DEFAULT);
    end else begin
      status <= (status & ~clr_mask) | set_mask;
      if (wr_en) begin
        case (addr)
          A_DIR:      dir      <= wdata;
          A_DOUT:     dout     <= wdata;
          A_IRQ_EN:   irq_en   <= wdata;
          A_RISE_EN:  rise_en  <= wdata;
          A_FALL_EN:  fall_en  <= wdata;
          A_DB_LIMIT: db_limit <= DB_W'(wdata);
          default:    ;
        endcase
      end
    end
  end

  // Read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

  // Synchroniser, debounce state and previous stable value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < int'(N_PINS); i++) cnt[i] <= '0;
    end else begin
      sync1    <= pin_in;
      sync2    <= sync1;
      stable   <= stable_nxt;
      stable_q <= stable;
      for (int i = 0; i < int'(N_PINS); i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: doc/gpio_ctrl_p.md
Name: gpio_ctrl_p

Overview:
- Parametrised GPIO controller, successor to the fixed 16-pin GPIO inside cu_main.
- Adds per-pin direction, a 2-flop input synchroniser and a programmable debounce filter.
- Adds per-pin rising/falling edge detection with sticky W1C interrupt status and a single irq output.
- Sits between the MCU register bus and the pad ring.

Parameters:
- N_PINS, 16, number of GPIO pins (1..32).
- DB_W, 4, width of the per-pin debounce counter and the DB_LIMIT field.
- DB_DEFAULT, 4, reset value of DB_LIMIT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  in  1  register write strobe, single cycle.
- rd_en  in  1  register read strobe, single cycle.
- addr  in  3  register address.
- wdata  in  N_PINS  write data.
- rdata  out  N_PINS  read data, registered.
- rvalid  out  1  high one cycle after rd_en.
- pin_in  in  N_PINS  raw pad inputs, asynchronous.
- pin_out  out  N_PINS  pad output data.
- pin_oe  out  N_PINS  pad output enable (1 = drive).
- irq  out  1  interrupt request.

Behaviour:
- Reset (reset=0, async):
  - DIR, DOUT, IRQ_EN, RISE_EN, FALL_EN, STATUS, sync flops, stable, counters all cleared to 0.
  - DB_LIMIT set to DB_DEFAULT.
  - rdata=0, rvalid=0, pin_out=0, pin_oe=0, irq=0.
- Reset release is synchronous to clk. The first functional edge is the first rising clk edge with reset=1.
- Register map (addr):
  - 0 DIR, RW, 1 = output.
  - 1 DOUT, RW.
  - 2 DIN, RO, debounced stable value.
  - 3 IRQ_EN, RW.
  - 4 RISE_EN, RW.
  - 5 FALL_EN, RW.
  - 6 STATUS, read / W1C.
  - 7 DB_LIMIT, RW, low DB_W bits used, upper bits read 0.
- Writes to RO addr 2 are ignored.
- Outputs: pin_oe = DIR and pin_out = DOUT, both direct from registers. A write is visible on the pads on the next cycle.
- Reads:
  - rdata and rvalid update on the edge after rd_en, so latency is 1.
  - rdata holds its value when rd_en=0. rvalid=0 when rd_en=0.
  - Simultaneous rd_en and wr_en to the same address returns the pre-write value.
- Synchroniser: pin_in passes through 2 flops per pin to give sync.
- Debounce (per pin; L = DB_LIMIT, with L=0 treated as 1):
  - If sync == stable, the counter clears.
  - Otherwise the counter increments. On the L-th consecutive mismatching edge, stable takes sync and the counter clears.
  - A mismatch that ends before L edges leaves stable unchanged and clears the counter.
  - Changing DB_LIMIT mid-count takes effect immediately. If the counter is already >= new L-1 and a mismatch persists, stable updates on the next edge.
  - The counter saturates and never wraps.
- Latency: a pin_in step held steady reaches DIN after 2+L edges. The STATUS bit sets 1 edge later, and irq rises in the same cycle as STATUS.
- Edge detect:
  - Rise = stable 0->1; fall = stable 1->0, taken from the registered previous stable value.
  - STATUS[i] sets on (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
  - Detection runs for inputs and outputs alike, independent of DIR.
- STATUS is sticky:
  - Cleared only by writing 1 to that bit at addr 6; writing 0 has no effect.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq = OR(STATUS & IRQ_EN), combinational from registers, so it is glitch-free.
  - Clearing IRQ_EN masks irq without clearing STATUS.
- Reset mid-operation clears all state, including in-flight debounce counts. No edge is reported for the transition back to 0.

Test Plan:
- Reset, then read all 8 addresses -> rvalid on the next cycle. Reads return 0, except DB_LIMIT = 4; irq = 0; pin_oe = 0.
- Write DIR=0x00FF, DOUT=0x00A5 -> pin_oe=0x00FF and pin_out=0x00A5 one cycle later. Read addr 1 -> 0x00A5.
- DB_LIMIT=4, pin_in[0] 0->1 held -> DIN[0]=1 exactly 6 edges after the pin change. A 3-cycle glitch on pin_in[1] -> DIN[1] stays 0 and STATUS=0.
- RISE_EN[0]=1, FALL_EN[0]=0, IRQ_EN[0]=1, pin_in[0] 0->1->0 (each held 20 cycles) -> STATUS=0x0001 and irq=1 after the rise. The fall adds nothing.
- With STATUS[0]=1, write 0x0001 to addr 6 in the same cycle a new enabled edge arrives on pin 0 -> STATUS[0] stays 1. Write again with no edge -> STATUS=0, irq=0.
- Set IRQ_EN=0 while STATUS[2]=1 -> irq drops, STATUS still reads 0x0004. Assert reset mid-debounce on pin 3 -> all outputs 0 and DB_LIMIT=4 after release, and the counter restarts from 0.
